// File: rtl/duc_pkg.sv
// duc_pkg: shared FSM state type and width helpers for the DUC interpolator stages
package duc_pkg;
    typedef enum logic [1:0] {S_IDLE, S_PH0, S_PH1} state_t;
    function automatic int out_width(int dw, int cw, int n);
        return dw + cw + $clog2(n);
    endfunction
    function automatic int nmax(int n0, int n1);
        return (n0 > n1) ? n0 : n1;
    endfunction
endpackage

// File: rtl/pp_phase_mac.sv
// pp_phase_mac: combinational signed dot product of N samples and N coefficients
// Ports: i_x  N packed signed samples, tap k at [k*DW +: DW]
//        i_c  N packed signed coefficients, tap k at [k*CW +: CW]
//        o_y  full-precision signed sum
module pp_phase_mac #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int N  = 20,
    parameter int OW = 37
) (
    input  logic [N*DW-1:0]     i_x,
    input  logic [N*CW-1:0]     i_c,
    output logic signed [OW-1:0] o_y
);
    always_comb begin
        logic signed [DW+CW-1:0] w_p;
        w_p = '0;
        o_y = '0;
        for (int k = 0; k < N; k++) begin
            w_p = (DW+CW)'($signed(i_x[k*DW +: DW])) * (DW+CW)'($signed(i_c[k*CW +: CW]));
            o_y = o_y + OW'(w_p);
        end
    end
endmodule

// File: rtl/pp_interpolator_2.sv
// pp_interpolator_2: polyphase interpolate-by-2 FIR stage with valid/ready on both sides
// Ports: clk/arst         clock, asynchronous active-high reset
//        bypass           pass samples through as a unity-coefficient product
//        coeffs           packed phase-0 then phase-1 taps (phase-0 tap 0 in the top slot)
//        src_*            input sample stream
//        dst_*            full-precision output stream, phase 0 then phase 1 per input
module pp_interpolator_2 import duc_pkg::*; #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int N_COEFFS_0  = 20,
    parameter int N_COEFFS_1  = 20,
    localparam int NMAX      = nmax(N_COEFFS_0, N_COEFFS_1),
    localparam int OUT_WIDTH = out_width(DATA_WIDTH, COEFF_WIDTH, NMAX)
) (
    input  logic                                          clk,
    input  logic                                          arst,
    input  logic                                          bypass,
    input  logic [(N_COEFFS_0+N_COEFFS_1)*COEFF_WIDTH-1:0] coeffs,
    input  logic signed [DATA_WIDTH-1:0]                  src_data_in,
    input  logic                                          src_valid_in,
    output logic                                          src_ready_out,
    output logic signed [OUT_WIDTH-1:0]                   dst_data_out,
    output logic                                          dst_valid_out,
    input  logic                                          dst_ready_in
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = COEFF_WIDTH;
    state_t                       r_st;
    logic signed [DW-1:0]         r_x [NMAX];
    logic [N_COEFFS_0*DW-1:0]     w_x0;
    logic [N_COEFFS_0*CW-1:0]     w_c0;
    logic [N_COEFFS_1*DW-1:0]     w_x1;
    logic [N_COEFFS_1*CW-1:0]     w_c1;
    logic signed [OUT_WIDTH-1:0]  w_y0;
    logic signed [OUT_WIDTH-1:0]  w_y1;
    logic signed [OUT_WIDTH-1:0]  w_byp;
    logic                         w_xfer;
    // Phase 0 sees the line as it will be after this transfer, so its result is ready at the accepting edge
    for (genvar k = 0; k < N_COEFFS_0; k++) begin : g_p0
        if (k == 0) begin : g_new
            assign w_x0[k*DW +: DW] = src_data_in;
        end else begin : g_old
            assign w_x0[k*DW +: DW] = r_x[k-1];
        end
        assign w_c0[k*CW +: CW] = coeffs[(N_COEFFS_0+N_COEFFS_1-1-k)*CW +: CW];
    end
    for (genvar k = 0; k < N_COEFFS_1; k++) begin : g_p1
        assign w_x1[k*DW +: DW] = r_x[k];
        assign w_c1[k*CW +: CW] = coeffs[(N_COEFFS_1-1-k)*CW +: CW];
    end
    pp_phase_mac #(.DW(DW), .CW(CW), .N(N_COEFFS_0), .OW(OUT_WIDTH)) u_mac0 (
        .i_x (w_x0),
        .i_c (w_c0),
        .o_y (w_y0)
    );
    pp_phase_mac #(.DW(DW), .CW(CW), .N(N_COEFFS_1), .OW(OUT_WIDTH)) u_mac1 (
        .i_x (w_x1),
        .i_c (w_c1),
        .o_y (w_y1)
    );
    assign w_byp         = OUT_WIDTH'(src_data_in) <<< (CW-1);
    assign src_ready_out = !arst && (r_st == S_IDLE || (r_st == S_PH1 && dst_ready_in));
    assign w_xfer        = src_valid_in && src_ready_out;
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_st          <= S_IDLE;
            dst_data_out  <= '0;
            dst_valid_out <= 1'b0;
            for (int k = 0; k < NMAX; k++) r_x[k] <= '0;
        end else if (w_xfer) begin
            r_x[0] <= src_data_in;
            for (int k = 1; k < NMAX; k++) r_x[k] <= r_x[k-1];
            dst_data_out  <= bypass ? w_byp : w_y0;
            dst_valid_out <= 1'b1;
            r_st          <= bypass ? S_PH1 : S_PH0;
        end else if (r_st == S_PH0 && dst_ready_in) begin
            dst_data_out <= w_y1;
            r_st         <= S_PH1;
        end else if (r_st == S_PH1 && dst_ready_in) begin
            dst_valid_out <= 1'b0;
            r_st          <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_pp_interpolator_2.sv
// tb_pp_interpolator_2: directed scoreboard bench for pp_interpolator_2
module tb_pp_interpolator_2;
    localparam int OW = 37;
    logic                    clk = 1'b0;
    logic                    arst = 1'b1;
    logic                    bypass = 1'b0;
    logic [40*16-1:0]        coeffs = '0;
    logic signed [15:0]      src_data_in = '0;
    logic                    src_valid_in = 1'b0;
    logic                    src_ready_out;
    logic signed [OW-1:0]    dst_data_out;
    logic                    dst_valid_out;
    logic                    dst_ready_in = 1'b0;
    logic signed [OW-1:0]    exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit track = 1'b0;
    int first_cyc = -1;
    int last_cyc = -1;
    int n_out = 0;
    pp_interpolator_2 dut (
        .clk           (clk),
        .arst          (arst),
        .bypass        (bypass),
        .coeffs        (coeffs),
        .src_data_in   (src_data_in),
        .src_valid_in  (src_valid_in),
        .src_ready_out (src_ready_out),
        .dst_data_out  (dst_data_out),
        .dst_valid_out (dst_valid_out),
        .dst_ready_in  (dst_ready_in)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!arst && dst_valid_out && dst_ready_in) begin
            if (track) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                n_out++;
            end
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got %0d, expected no output", dst_data_out);
            end else begin
                chk("out", dst_data_out, exp_q.pop_front());
            end
        end
    end
    task automatic push(input int v);
        exp_q.push_back(OW'(v));
    endtask
    task automatic send(input logic signed [15:0] d);
        bit ok = 1'b0;
        src_data_in  = d;
        src_valid_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (src_ready_out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got ready 0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        src_valid_in = 1'b0;
    endtask
    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_reset();
        arst = 1'b1;
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask
    task automatic set_impulse();
        coeffs = '0;
        coeffs[39*16 +: 16] = 16'sd16384;
        coeffs[18*16 +: 16] = -16'sd16384;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", dst_valid_out, 0);
        chk("rst_ready_in_reset", src_ready_out, 0);
        chk("rst_data", dst_data_out, 0);
        arst = 1'b0;
        #1;
        chk("rst_ready_after", src_ready_out, 1);
        // impulse response
        set_impulse();
        dst_ready_in = 1'b1;
        push(16384000); push(0); push(0); push(-16384000);
        send(1000);
        send(0);
        drain();
        // full rate, all taps 1
        pulse_reset();
        for (int s = 0; s < 40; s++) coeffs[s*16 +: 16] = 16'sd1;
        track = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            push((k < 20 ? k : 20) * 100);
            push((k < 20 ? k : 20) * 100);
            send(100);
        end
        drain();
        track = 1'b0;
        chk("full_rate_count", n_out, 48);
        chk("full_rate_no_gaps", last_cyc - first_cyc, 47);
        // backpressure in phase 0
        pulse_reset();
        set_impulse();
        dst_ready_in = 1'b0;
        push(8192000); push(0);
        send(500);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", dst_valid_out, 1);
            chk("bp_data", dst_data_out, 8192000);
            chk("bp_src_ready", src_ready_out, 0);
        end
        @(posedge clk);
        #1;
        dst_ready_in = 1'b1;
        push(0); push(-8192000);
        send(0);
        drain();
        // bypass, one input per cycle
        bypass = 1'b1;
        begin
            int c0;
            c0 = cyc;
            push(-1073741824); push(-1073741824); push(404520960);
            send(-16'sd32768);
            send(-16'sd32768);
            send(16'sd12345);
            chk("byp_rate", cyc - c0, 3);
        end
        drain();
        bypass = 1'b0;
        // reset mid-pair discards the pair and clears the line
        dst_ready_in = 1'b0;
        send(700);
        #2;
        arst = 1'b1;
        #1;
        chk("arst_valid", dst_valid_out, 0);
        chk("arst_src_ready", src_ready_out, 0);
        chk("arst_data", dst_data_out, 0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        #1;
        chk("arst_ready_after", src_ready_out, 1);
        dst_ready_in = 1'b1;
        push(16384000); push(0); push(0); push(-16384000);
        send(1000);
        send(0);
        drain();
        // bypass toggled while phase 0 is pending
        push(4915200); push(0);
        send(300);
        drain();
        dst_ready_in = 1'b0;
        push(3276800); push(-4915200);
        send(200);
        bypass = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("tog_hold", dst_data_out, 3276800);
        dst_ready_in = 1'b1;
        push(229376);
        send(7);
        bypass = 1'b0;
        push(0); push(-114688);
        send(0);
        drain();
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
